// File: rtl/scan_mux_demux.sv
// scan_mux_demux: registered N-channel mux/demux pair sharing one selector (manual sel or round-robin scan).
// Build option SCAN_MUX_PARITY_EN adds o_mux_parity, the XOR of each word loaded into o_mux_out.
module scan_mux_demux #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_en,
   input  logic                      i_mode,
   input  logic [SEL_W-1:0]          i_sel,
   input  logic [CHANNELS*WIDTH-1:0] i_mux_in,
   output logic [WIDTH-1:0]          o_mux_out,
   output logic [SEL_W-1:0]          o_mux_ch,
   output logic                      o_mux_valid,
   input  logic [WIDTH-1:0]          i_demux_in,
   input  logic                      i_demux_we,
   output logic [CHANNELS*WIDTH-1:0] o_demux_out,
   output logic                      o_frame_done
`ifdef SCAN_MUX_PARITY_EN
   ,
   output logic                      o_mux_parity
`endif
);

   localparam logic [SEL_W:0]   LP_CH_CNT = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(CHANNELS-1);

`ifdef SCAN_MUX_PARITY_EN
   function automatic logic f_parity(input logic [WIDTH-1:0] i_word);
      return ^i_word;
   endfunction
`endif

   // Wrap at CHANNELS-1 so the pointer never leaves the valid range, even for non-power-of-2 counts.
   function automatic logic [SEL_W-1:0] f_next_ptr(input logic [SEL_W-1:0] i_ptr);
      logic [SEL_W-1:0] v_next;
      if (i_ptr == LP_LAST) begin
         v_next = {SEL_W{1'b0}};
      end else begin
         v_next = i_ptr + {{(SEL_W-1){1'b0}}, 1'b1};
      end
      return v_next;
   endfunction

   logic [SEL_W-1:0]          r_ptr;
   logic [WIDTH-1:0]          r_mux_out;
   logic [SEL_W-1:0]          r_mux_ch;
   logic                      r_mux_valid;
   logic                      r_frame_done;
   logic [CHANNELS*WIDTH-1:0] r_demux;

   logic [SEL_W-1:0]          w_cur;
   logic                      w_cur_valid;
   logic                      w_ptr_last;
   logic                      w_advance;
   logic [WIDTH-1:0]          w_word;
   logic [CHANNELS-1:0]       w_wr_hot;

   assign w_cur       = i_mode ? r_ptr : i_sel;
   assign w_cur_valid = ({1'b0, w_cur} < LP_CH_CNT);
   assign w_ptr_last  = (r_ptr == LP_LAST);
   assign w_advance   = i_en & i_mode;

   // AND-OR select keeps out-of-range selectors from indexing past the packed input.
   always_comb begin
      w_word   = {WIDTH{1'b0}};
      w_wr_hot = {CHANNELS{1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
         w_word      = w_word | (i_mux_in[k*WIDTH +: WIDTH] & {WIDTH{w_cur == SEL_W'(k)}});
         w_wr_hot[k] = i_demux_we & (w_cur == SEL_W'(k));
      end
   end

   // Mux output register: loads only on a valid enabled sample, otherwise holds.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mux_out   <= {WIDTH{1'b0}};
         r_mux_ch    <= {SEL_W{1'b0}};
         r_mux_valid <= 1'b0;
      end else if (i_en && w_cur_valid) begin
         r_mux_out   <= w_word;
         r_mux_ch    <= w_cur;
         r_mux_valid <= 1'b1;
      end else begin
         r_mux_valid <= 1'b0;
      end
   end

   // Scan pointer and end-of-frame pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr        <= {SEL_W{1'b0}};
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_advance & w_ptr_last;
         if (w_advance) begin
            r_ptr <= f_next_ptr(r_ptr);
         end
      end
   end

   // Demux holding bank.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_demux <= {(CHANNELS*WIDTH){1'b0}};
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_wr_hot[k]) begin
               r_demux[k*WIDTH +: WIDTH] <= i_demux_in;
            end
         end
      end
   end

`ifdef SCAN_MUX_PARITY_EN
   logic r_mux_parity;

   // Parity tracks exactly the loads of r_mux_out.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mux_parity <= 1'b0;
      end else if (i_en && w_cur_valid) begin
         r_mux_parity <= f_parity(w_word);
      end else begin
         r_mux_parity <= r_mux_parity;
      end
   end

   assign o_mux_parity = r_mux_parity;
`endif

   assign o_mux_out    = r_mux_out;
   assign o_mux_ch     = r_mux_ch;
   assign o_mux_valid  = r_mux_valid;
   assign o_demux_out  = r_demux;
   assign o_frame_done = r_frame_done;

   scan_mux_demux_chk #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_chk (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_ptr        (r_ptr),
      .i_mux_ch     (r_mux_ch),
      .i_mux_valid  (r_mux_valid),
      .i_frame_done (r_frame_done)
   );

endmodule

// scan_mux_demux_chk: structural invariants of the scan pointer and frame pulse.
module scan_mux_demux_chk #(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input logic             i_clk,
   input logic             i_reset,
   input logic [SEL_W-1:0] i_ptr,
   input logic [SEL_W-1:0] i_mux_ch,
   input logic             i_mux_valid,
   input logic             i_frame_done
);

   localparam logic [SEL_W:0]   LP_CH_CNT = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(CHANNELS-1);

   a_ptr_range : assert property (@(posedge i_clk) ({1'b0, i_ptr} < LP_CH_CNT));

   a_frame_ch : assert property (@(posedge i_clk) disable iff (i_reset)
      i_frame_done |-> (i_mux_valid && (i_mux_ch == LP_LAST)));

endmodule

// File: tb/tb_scan_mux_demux.sv
// Directed bench for scan_mux_demux: a CHANNELS=4 instance and a CHANNELS=3 instance share one clock and reset.
module tb_scan_mux_demux;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_en, a_mode, a_we;
   logic [1:0]  a_sel;
   logic [31:0] a_mux_in;
   logic [7:0]  a_demux_in;
   logic [7:0]  a_mux_out;
   logic [1:0]  a_mux_ch;
   logic        a_mux_valid, a_fd;
   logic [31:0] a_demux_out;

   logic        b_en, b_mode, b_we;
   logic [1:0]  b_sel;
   logic [23:0] b_mux_in;
   logic [7:0]  b_demux_in;
   logic [7:0]  b_mux_out;
   logic [1:0]  b_mux_ch;
   logic        b_mux_valid, b_fd;
   logic [23:0] b_demux_out;
`ifdef SCAN_MUX_PARITY_EN
   logic        a_parity, b_parity;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   scan_mux_demux #(.WIDTH(8), .CHANNELS(4)) u_a (
      .i_clk(clk), .i_reset(reset), .i_en(a_en), .i_mode(a_mode), .i_sel(a_sel),
      .i_mux_in(a_mux_in), .o_mux_out(a_mux_out), .o_mux_ch(a_mux_ch), .o_mux_valid(a_mux_valid),
      .i_demux_in(a_demux_in), .i_demux_we(a_we), .o_demux_out(a_demux_out), .o_frame_done(a_fd)
`ifdef SCAN_MUX_PARITY_EN
      , .o_mux_parity(a_parity)
`endif
   );

   scan_mux_demux #(.WIDTH(8), .CHANNELS(3)) u_b (
      .i_clk(clk), .i_reset(reset), .i_en(b_en), .i_mode(b_mode), .i_sel(b_sel),
      .i_mux_in(b_mux_in), .o_mux_out(b_mux_out), .o_mux_ch(b_mux_ch), .o_mux_valid(b_mux_valid),
      .i_demux_in(b_demux_in), .i_demux_we(b_we), .o_demux_out(b_demux_out), .o_frame_done(b_fd)
`ifdef SCAN_MUX_PARITY_EN
      , .o_mux_parity(b_parity)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] out, input logic [1:0] ch,
                        input logic vld, input logic fd);
      chk({tag, ".mux_out"}, 64'(a_mux_out), 64'(out));
      chk({tag, ".mux_ch"}, 64'(a_mux_ch), 64'(ch));
      chk({tag, ".mux_valid"}, 64'(a_mux_valid), 64'(vld));
      chk({tag, ".frame_done"}, 64'(a_fd), 64'(fd));
   endtask

   task automatic chk_b(input string tag, input logic [7:0] out, input logic [1:0] ch,
                        input logic vld, input logic fd);
      chk({tag, ".mux_out"}, 64'(b_mux_out), 64'(out));
      chk({tag, ".mux_ch"}, 64'(b_mux_ch), 64'(ch));
      chk({tag, ".mux_valid"}, 64'(b_mux_valid), 64'(vld));
      chk({tag, ".frame_done"}, 64'(b_fd), 64'(fd));
   endtask

   initial begin
      // Reset with random activity on A.
      reset = 1'b1;
      a_en = 1'b1; a_mode = 1'b1; a_we = 1'b1; a_sel = 2'($urandom_range(0, 3));
      a_mux_in = $urandom; a_demux_in = 8'($urandom_range(0, 255));
      b_en = 1'b0; b_mode = 1'b0; b_we = 1'b0; b_sel = 2'd0; b_mux_in = 24'h332211; b_demux_in = 8'h00;
      tick();
      a_mux_in = $urandom; a_demux_in = 8'($urandom_range(0, 255));
      tick();
      chk_a("rst", 8'h00, 2'd0, 1'b0, 1'b0);
      chk("rst.demux", 64'(a_demux_out), 64'h0);
      chk_b("rst_b", 8'h00, 2'd0, 1'b0, 1'b0);
      chk("rst_b.demux", 64'(b_demux_out), 64'h0);
`ifdef SCAN_MUX_PARITY_EN
      chk("rst.parity", 64'(a_parity), 64'h0);
`endif

      reset = 1'b0; a_en = 1'b0; a_we = 1'b0; a_mode = 1'b0;
      tick();
      chk_a("post_rst", 8'h00, 2'd0, 1'b0, 1'b0);

      // Manual select.
      a_mux_in = 32'hD3C2B1A0; a_sel = 2'd2; a_en = 1'b1;
      tick();
      chk_a("man", 8'hC2, 2'd2, 1'b1, 1'b0);
      a_en = 1'b0;
      tick();
      chk_a("man_hold", 8'hC2, 2'd2, 1'b0, 1'b0);

      // Scan wrap from ptr 0.
      a_mode = 1'b1; a_en = 1'b1;
      tick(); chk_a("scan0", 8'hA0, 2'd0, 1'b1, 1'b0);
      tick(); chk_a("scan1", 8'hB1, 2'd1, 1'b1, 1'b0);
      tick(); chk_a("scan2", 8'hC2, 2'd2, 1'b1, 1'b0);
      tick(); chk_a("scan3", 8'hD3, 2'd3, 1'b1, 1'b1);
      tick(); chk_a("scan4", 8'hA0, 2'd0, 1'b1, 1'b0);
      tick(); chk_a("scan5", 8'hB1, 2'd1, 1'b1, 1'b0);
      tick(); chk_a("scan6", 8'hC2, 2'd2, 1'b1, 1'b0);
      tick(); chk_a("scan7", 8'hD3, 2'd3, 1'b1, 1'b1);

      // Demux fill over one frame, ptr starts at 0.
      a_we = 1'b1;
      a_demux_in = 8'h10; tick();
      chk("fill0", 64'(a_demux_out), 64'h00000010);
      a_demux_in = 8'h11; tick();
      a_demux_in = 8'h12; tick();
      a_demux_in = 8'h13; tick();
      chk("fill", 64'(a_demux_out), 64'h13121110);
      chk("fill.fd", 64'(a_fd), 64'h1);
      a_we = 1'b0; a_en = 1'b0; a_demux_in = 8'hEE;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("fill_hold", 64'(a_demux_out), 64'h13121110);
      end
      chk("idle.valid", 64'(a_mux_valid), 64'h0);

      // Reset mid-scan.
      a_en = 1'b1;
      tick(); chk("mid0.ch", 64'(a_mux_ch), 64'h0);
      tick(); chk("mid1.ch", 64'(a_mux_ch), 64'h1);
      reset = 1'b1;
      tick();
      chk_a("mid_rst", 8'h00, 2'd0, 1'b0, 1'b0);
      chk("mid_rst.demux", 64'(a_demux_out), 64'h0);
      reset = 1'b0;
      tick(); chk_a("resume0", 8'hA0, 2'd0, 1'b1, 1'b0);
      chk("resume0.demux", 64'(a_demux_out), 64'h0);
      tick(); chk_a("resume1", 8'hB1, 2'd1, 1'b1, 1'b0);
      tick(); chk_a("resume2", 8'hC2, 2'd2, 1'b1, 1'b0);
      a_we = 1'b1; a_demux_in = 8'h55;
      tick(); chk_a("resume3", 8'hD3, 2'd3, 1'b1, 1'b1);
      chk("resume3.demux", 64'(a_demux_out), 64'h55000000);

      // Manual demux write, independent of en; mux holds.
      a_mode = 1'b0; a_sel = 2'd1; a_en = 1'b0; a_demux_in = 8'hAA;
      tick(); chk_a("man_wr", 8'hD3, 2'd3, 1'b0, 1'b0);
      chk("man_wr.demux", 64'(a_demux_out), 64'h5500AA00);

      // Mode changes mid-frame: ptr held at 0, then 1.
      a_we = 1'b0; a_mode = 1'b1; a_en = 1'b1;
      tick(); chk_a("mode_s", 8'hA0, 2'd0, 1'b1, 1'b0);
      a_mode = 1'b0; a_sel = 2'd3;
      tick(); chk_a("mode_m", 8'hD3, 2'd3, 1'b1, 1'b0);
      a_mode = 1'b1;
      tick(); chk_a("mode_r", 8'hB1, 2'd1, 1'b1, 1'b0);
      a_en = 1'b0;

      // CHANNELS=3: valid manual write/sample, then out-of-range selector.
      b_mode = 1'b0; b_sel = 2'd1; b_en = 1'b1; b_we = 1'b1; b_demux_in = 8'h5A;
      tick(); chk_b("b_man", 8'h22, 2'd1, 1'b1, 1'b0);
      chk("b_man.demux", 64'(b_demux_out), 64'h005A00);
      b_sel = 2'd3; b_demux_in = 8'hFF;
      tick(); chk_b("b_oor", 8'h22, 2'd1, 1'b0, 1'b0);
      chk("b_oor.demux", 64'(b_demux_out), 64'h005A00);

      // CHANNELS=3 scan wraps after channel 2.
      b_we = 1'b0; b_mode = 1'b1;
      tick(); chk_b("b_scan0", 8'h11, 2'd0, 1'b1, 1'b0);
      tick(); chk_b("b_scan1", 8'h22, 2'd1, 1'b1, 1'b0);
      tick(); chk_b("b_scan2", 8'h33, 2'd2, 1'b1, 1'b1);
      tick(); chk_b("b_scan3", 8'h11, 2'd0, 1'b1, 1'b0);

`ifdef SCAN_MUX_PARITY_EN
      b_mode = 1'b0; b_sel = 2'd0; b_mux_in = 24'h332207;
      tick(); chk("b_par07", 64'(b_parity), 64'h1);
      b_sel = 2'd3;
      tick(); chk("b_par_hold", 64'(b_parity), 64'h1);
      b_sel = 2'd1;
      tick(); chk("b_par22", 64'(b_parity), 64'h0);
`endif
      b_en = 1'b0;
      tick();
      chk("b_idle.valid", 64'(b_mux_valid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scan_mux_demux.md
Name: scan_mux_demux

Overview:
- Parametrised, registered N-channel multiplexer/demultiplexer pair sharing one channel selector.
- The selector is driven either manually by `sel` or by an internal round-robin scan pointer.
- The mux side serialises `CHANNELS` words onto one registered output tagged with its channel number.
- The demux side writes a serial input into per-channel holding registers that keep their value until rewritten. It is the clocked, generalised successor of the team's 4:1 mux and 1:4 demux.

Parameters:
- WIDTH, 8, bits per channel word (>=1)
- CHANNELS, 4, number of channels (>=2, need not be a power of 2)
- SEL_W, $clog2(CHANNELS), localparam, width of channel index

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  mux sample enable; in scan mode, also advances the pointer
- mode  in  1  0 = manual (use `sel`), 1 = scan (use internal `ptr`)
- sel  in  SEL_W  manual channel select
- mux_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- mux_out  out  WIDTH  registered selected word
- mux_ch  out  SEL_W  channel index of current `mux_out`
- mux_valid  out  1  `mux_out` updated this cycle
- demux_in  in  WIDTH  word to store
- demux_we  in  1  write enable for the demux bank
- demux_out  out  CHANNELS*WIDTH  held per-channel registers, same packing as `mux_in`
- frame_done  out  1  one-cycle pulse on scan wrap

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and applied only on a rising `clk` edge. Reset has priority over every other input.
- Reset values: `ptr` = 0; `mux_out`, `mux_ch`, `mux_valid`, `demux_out` and `frame_done` are all 0.
- Current channel (combinational, internal): `cur` = `mode` ? `ptr` : `sel`.
- `cur` is valid iff `cur` < CHANNELS. `ptr` is always valid; `sel` may not be.
- Mux path, latency 1 cycle from input to registered output:
  - `en`=1 and `cur` valid: `mux_out` <= `mux_in`[`cur`]; `mux_ch` <= `cur`; `mux_valid` <= 1.
  - `en`=1 and `cur` invalid: `mux_out`/`mux_ch` hold; `mux_valid` <= 0.
  - `en`=0: `mux_out`/`mux_ch` hold; `mux_valid` <= 0.
- Scan pointer:
  - Advances only when `en`=1 and `mode`=1: `ptr` <= (`ptr`==CHANNELS-1) ? 0 : `ptr`+1.
  - Holds in manual mode. Switching back to scan resumes from the held `ptr`.
  - Never takes a value >= CHANNELS.
- `frame_done` <= `en` & `mode` & (`ptr`==CHANNELS-1); 0 otherwise. It asserts in the same cycle that `mux_out` shows channel CHANNELS-1.
- Demux path, latency 1 cycle:
  - `demux_we`=1 and `cur` valid: `demux_out`[`cur`] <= `demux_in`. All other channels hold.
  - `demux_we`=1 and `cur` invalid: write dropped, all channels hold.
  - `demux_we` is independent of `en`; it uses the pre-advance `cur` of the same cycle.
- Simultaneous `en` and `demux_we`: both use the same `cur`. Mux sample, demux write and pointer advance all occur on the same edge.
- Mode change mid-frame: takes effect on the same cycle. No flush, no `frame_done`.
- Reset mid-frame: pointer returns to 0 and the demux bank clears. Partially written frames are lost.
- No latches. Every output is a flop.

Optional Feature:
- Macro: SCAN_MUX_PARITY_EN
- Defined:
  - Adds output port `mux_parity` (out, 1), registered alongside `mux_out`.
  - Equals XOR of the word loaded into `mux_out`; updates only when `mux_out` updates; holds otherwise; reset value 0.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan (defaults WIDTH=8, CHANNELS=4 unless noted):
- Reset: hold `reset`=1 for 2 cycles with random inputs -> all outputs 0 and `frame_done`=0 on the first edge after `reset` falls.
- Manual select: `mux_in`=0xD3C2B1A0, `mode`=0, `sel`=2, `en`=1 for 1 cycle -> next cycle `mux_out`=0xC2, `mux_ch`=2, `mux_valid`=1. Then `en`=0 -> `mux_valid`=0, `mux_out` holds 0xC2.
- Scan wrap: `mode`=1, `en`=1 for 5 cycles -> `mux_out` sequence A0, B1, C2, D3, A0; `mux_ch` sequence 0, 1, 2, 3, 0; `frame_done`=1 only alongside D3.
- Demux fill: `mode`=1, `en`=1, `demux_we`=1, `demux_in` = 0x10, 0x11, 0x12, 0x13 over 4 cycles -> `demux_out`=0x13121110. Then `demux_we`=0 for 10 cycles -> value holds.
- Reset mid-scan: 2 scan cycles, then `reset` for 1 cycle, then resume scan -> first `mux_ch`=0; `demux_out`=0 until rewritten; no spurious `frame_done`.
- Out-of-range (CHANNELS=3): `mode`=0, `sel`=3, `en`=1, `demux_we`=1 -> `mux_valid`=0, `mux_out` unchanged, `demux_out` unchanged. If SCAN_MUX_PARITY_EN is defined, `sel`=0 with `mux_in`[0]=0x07 -> `mux_parity`=1.
